// File: rtl/deser_fifo_if.sv
// deser_fifo_if: serial capture / FIFO bus.
//   master: drives data_in, write_in, enqueue_in, dequeue_in; observes status and data.
//   slave : the deser_fifo block itself.
//   Status/data: status_out, word_ready_out, data_out[WIDTH], data_valid_out,
//                len_out[$clog2(DEPTH)+1], full_out, empty_out, overflow_out, underflow_out.
interface deser_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                     data_in;
    logic                     write_in;
    logic                     enqueue_in;
    logic                     dequeue_in;
    logic                     status_out;
    logic                     word_ready_out;
    logic [WIDTH-1:0]         data_out;
    logic                     data_valid_out;
    logic [$clog2(DEPTH):0]   len_out;
    logic                     full_out;
    logic                     empty_out;
    logic                     overflow_out;
    logic                     underflow_out;

    modport master (
        output data_in, write_in, enqueue_in, dequeue_in,
        input  status_out, word_ready_out, data_out, data_valid_out,
        input  len_out, full_out, empty_out, overflow_out, underflow_out
    );

    modport slave (
        input  data_in, write_in, enqueue_in, dequeue_in,
        output status_out, word_ready_out, data_out, data_valid_out,
        output len_out, full_out, empty_out, overflow_out, underflow_out
    );
endinterface

// File: rtl/deser_fifo.sv
// deser_fifo: serial-to-parallel shifter feeding a DEPTH-entry circular FIFO.
//   clock_1MHz : system clock, rising edge
//   rst        : synchronous active-low reset
//   bus        : deser_fifo_if.slave (serial in, enqueue/dequeue requests,
//                popped word, occupancy and sticky error flags)
// Bits shift in while the shifter is accepting; a completed word is held until
// an enqueue edge pushes it. Dequeue edges pop the head to a registered output.
module deser_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clock_1MHz,
    input  logic         rst,
    deser_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH);
    localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
    localparam logic [AW:0]   LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH-1);

    typedef enum logic {S_SHIFT, S_HELD} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      len_q, len_d;
    logic             full_q, empty_q;
    logic             enq_q, deq_q;
    logic             enq_edge, deq_edge, do_enq, do_deq;
    logic             shift_en, last_bit;
    logic [WIDTH-1:0] dout_q;
    logic             dvld_q, ovf_q, unf_q;

    always_comb begin
        enq_edge = bus.enqueue_in & ~enq_q;
        deq_edge = bus.dequeue_in & ~deq_q;
        shift_en = (state_q == S_SHIFT) & bus.write_in;
        last_bit = shift_en & (bit_cnt == CNT_LAST);
        do_deq   = deq_edge & ~empty_q;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        do_enq   = enq_edge & (state_q == S_HELD) & (~full_q | do_deq);

        if (MSB_FIRST) shift_d = {shift_q[WIDTH-2:0], bus.data_in};
        else           shift_d = {bus.data_in, shift_q[WIDTH-1:1]};

        len_d = len_q;
        if (do_enq & ~do_deq)      len_d = len_q + LEN_ONE;
        else if (do_deq & ~do_enq) len_d = len_q - LEN_ONE;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_SHIFT: if (last_bit) state_d = S_HELD;
            S_HELD:  if (do_enq)   state_d = S_SHIFT;
            default: state_d = S_SHIFT;
        endcase
    end

    always_ff @(posedge clock_1MHz) begin
        if (!rst) begin
            state_q <= S_SHIFT;
            bit_cnt <= '0;
            shift_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            len_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            enq_q   <= 1'b0;
            deq_q   <= 1'b0;
            dout_q  <= '0;
            dvld_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            enq_q   <= bus.enqueue_in;
            deq_q   <= bus.dequeue_in;
            if (shift_en) begin
                shift_q <= shift_d;
                bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
            end
            if (do_enq) wr_ptr <= wr_ptr + AW'(1);
            if (do_deq) begin
                rd_ptr <= rd_ptr + AW'(1);
                dout_q <= mem[rd_ptr];
            end
            dvld_q  <= do_deq;
            len_q   <= len_d;
            full_q  <= (len_d == LEN_MAX);
            empty_q <= (len_d == '0);
            if (enq_edge & (state_q == S_HELD) & full_q & ~do_deq) ovf_q <= 1'b1;
            if (deq_edge & empty_q)                                unf_q <= 1'b1;
        end
    end

    // Storage has no reset; stale entries are never read because len_q gates pops.
    always_ff @(posedge clock_1MHz) begin
        if (rst && do_enq) mem[wr_ptr] <= shift_q;
    end

    assign bus.status_out     = (state_q == S_SHIFT);
    assign bus.word_ready_out = (state_q == S_HELD);
    assign bus.data_out       = dout_q;
    assign bus.data_valid_out = dvld_q;
    assign bus.len_out        = len_q;
    assign bus.full_out       = full_q;
    assign bus.empty_out      = empty_q;
    assign bus.overflow_out   = ovf_q;
    assign bus.underflow_out  = unf_q;
endmodule

// File: tb/tb_deser_fifo.sv
`timescale 1ns/1ps
// Drives an MSB-first and an LSB-first instance with the same serial stream;
// the LSB-first one must produce the bit-reversed word.
module tb_deser_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic din = 1'b0, wr = 1'b0, enq = 1'b0, deq = 1'b0;

    always #500 clk = ~clk;

    deser_fifo_if #(.WIDTH(8), .DEPTH(4)) ifa ();
    deser_fifo_if #(.WIDTH(8), .DEPTH(4)) ifb ();

    assign ifa.data_in = din;  assign ifb.data_in = din;
    assign ifa.write_in = wr;  assign ifb.write_in = wr;
    assign ifa.enqueue_in = enq; assign ifb.enqueue_in = enq;
    assign ifa.dequeue_in = deq; assign ifb.dequeue_in = deq;

    deser_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) dut_a (
        .clock_1MHz(clk), .rst(rst), .bus(ifa));
    deser_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) dut_b (
        .clock_1MHz(clk), .rst(rst), .bus(ifb));

    int n_chk = 0, n_fail = 0;
    int n_vld_a = 0, n_vld_b = 0, n_pop_exp = 0;

    logic [7:0] qa[$], qb[$];
    logic [7:0] last_a = 8'h00, last_b = 8'h00;
    logic [7:0] exp_a, exp_b;
    logic [7:0] word_held = 8'h00;
    logic       held = 1'b0, exp_ovf = 1'b0, exp_unf = 1'b0;
    int         mlen = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output-side scoreboard: every valid pulse pops one expected word.
    always @(negedge clk) begin
        if (rst && ifa.data_valid_out) begin
            n_vld_a++;
            if (qa.size() == 0) chk("vld_a_unexpected", 1, 0);
            else begin
                exp_a = qa.pop_front();
                chk("pop_a", int'(ifa.data_out), int'(exp_a));
                last_a = exp_a;
            end
        end
        if (rst && ifb.data_valid_out) begin
            n_vld_b++;
            if (qb.size() == 0) chk("vld_b_unexpected", 1, 0);
            else begin
                exp_b = qb.pop_front();
                chk("pop_b", int'(ifb.data_out), int'(exp_b));
                last_b = exp_b;
            end
        end
    end

    task automatic chk_state(input string tag);
        chk({tag, "_status_a"}, int'(ifa.status_out), int'(!held));
        chk({tag, "_status_b"}, int'(ifb.status_out), int'(!held));
        chk({tag, "_ready_a"},  int'(ifa.word_ready_out), int'(held));
        chk({tag, "_ready_b"},  int'(ifb.word_ready_out), int'(held));
        chk({tag, "_len_a"},    int'(ifa.len_out), mlen);
        chk({tag, "_len_b"},    int'(ifb.len_out), mlen);
        chk({tag, "_full_a"},   int'(ifa.full_out), int'(mlen == 4));
        chk({tag, "_empty_a"},  int'(ifa.empty_out), int'(mlen == 0));
        chk({tag, "_empty_b"},  int'(ifb.empty_out), int'(mlen == 0));
        chk({tag, "_ovf_a"},    int'(ifa.overflow_out), int'(exp_ovf));
        chk({tag, "_ovf_b"},    int'(ifb.overflow_out), int'(exp_ovf));
        chk({tag, "_unf_a"},    int'(ifa.underflow_out), int'(exp_unf));
        chk({tag, "_unf_b"},    int'(ifb.underflow_out), int'(exp_unf));
        chk({tag, "_vld_a"},    int'(ifa.data_valid_out), 0);
        chk({tag, "_dout_a"},   int'(ifa.data_out), int'(last_a));
        chk({tag, "_dout_b"},   int'(ifb.data_out), int'(last_b));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0; wr = 1'b0; enq = 1'b0; deq = 1'b0;
        tick(); tick();
        qa.delete(); qb.delete();
        mlen = 0; held = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
        last_a = 8'h00; last_b = 8'h00;
        chk_state(tag);
        rst = 1'b1;
        tick();
    endtask

    // Serial stream always sent w[7] first.
    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            din = w[i]; wr = 1'b1;
            tick();
        end
        wr = 1'b0; din = 1'b0;
        if (!held) begin held = 1'b1; word_held = w; end
    endtask

    // Raise enqueue/dequeue together for n cycles; the model sees one edge.
    task automatic op(input logic e, input logic d, input int n);
        logic do_d, do_e;
        do_d = d && (mlen > 0);
        do_e = e && held && ((mlen < 4) || do_d);
        if (e && held && !do_e) exp_ovf = 1'b1;
        if (d && mlen == 0)     exp_unf = 1'b1;
        if (do_e) begin
            qa.push_back(word_held); qb.push_back(rev8(word_held));
            held = 1'b0;
        end
        if (do_d) n_pop_exp++;
        mlen = mlen + int'(do_e) - int'(do_d);
        enq = e; deq = d;
        for (int i = 0; i < n; i++) tick();
        enq = 1'b0; deq = 1'b0;
        tick();
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vld_before;
        do_reset("reset");

        // Basic capture B2 / 4D
        send_word(8'hB2);
        chk_state("held_b2");
        op(1'b1, 1'b0, 1);
        chk_state("enq_b2");
        op(1'b0, 1'b1, 1);
        chk_state("deq_b2");
        chk("b2_dout_a", int'(ifa.data_out), 32'hB2);
        chk("b2_dout_b", int'(ifb.data_out), 32'h4D);

        // Enqueue held high: one push only; writes while held are ignored
        send_word(8'h5A);
        op(1'b1, 1'b0, 5);
        chk_state("enq_hold");
        chk("enq_hold_len", int'(ifa.len_out), 1);
        send_word(8'hC3);
        for (int i = 0; i < 3; i++) begin
            din = i[0]; wr = 1'b1; tick();
        end
        wr = 1'b0;
        chk_state("extra_wr");
        op(1'b1, 1'b0, 1);
        op(1'b0, 1'b1, 1);
        op(1'b0, 1'b1, 1);
        chk_state("drain1");

        // Fill, overflow, drain, underflow
        send_word(8'h11); op(1'b1, 1'b0, 1);
        send_word(8'h22); op(1'b1, 1'b0, 1);
        send_word(8'h33); op(1'b1, 1'b0, 1);
        send_word(8'h44); op(1'b1, 1'b0, 1);
        chk_state("full");
        chk("full_flag", int'(ifa.full_out), 1);
        send_word(8'h55); op(1'b1, 1'b0, 1);
        chk_state("overflow");
        chk("ovf_flag", int'(ifa.overflow_out), 1);
        for (int i = 0; i < 4; i++) op(1'b0, 1'b1, 1);
        chk_state("drained");
        vld_before = n_vld_a;
        op(1'b0, 1'b1, 1);
        chk_state("underflow");
        chk("unf_no_pulse", n_vld_a, vld_before);
        chk("unf_dout_a", int'(ifa.data_out), 32'h44);

        // Pointer wrap and same-cycle push/pop while full
        do_reset("reset2");
        send_word(8'h55); op(1'b1, 1'b0, 1);
        send_word(8'h66); op(1'b1, 1'b0, 1);
        send_word(8'h77); op(1'b1, 1'b0, 1);
        op(1'b0, 1'b1, 1); op(1'b0, 1'b1, 1);
        send_word(8'h88); op(1'b1, 1'b0, 1);
        send_word(8'h99); op(1'b1, 1'b0, 1);
        send_word(8'hAA); op(1'b1, 1'b0, 1);
        chk_state("wrap_full");
        send_word(8'hBB); op(1'b1, 1'b1, 1);
        chk_state("full_simul");
        chk("full_simul_ovf", int'(ifa.overflow_out), 0);
        for (int i = 0; i < 4; i++) op(1'b0, 1'b1, 1);
        chk_state("wrap_drained");

        // Reset mid-word with entries queued
        send_word(8'hC1); op(1'b1, 1'b0, 1);
        send_word(8'hC2); op(1'b1, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            din = 1'b1; wr = 1'b1; tick();
        end
        do_reset("reset_mid");
        send_word(8'hE7); op(1'b1, 1'b0, 1);
        op(1'b0, 1'b1, 1);
        chk_state("after_reset");
        chk("e7_dout_a", int'(ifa.data_out), 32'hE7);

        // Push and pop together while empty: push only, underflow flagged
        vld_before = n_vld_a;
        send_word(8'h3C); op(1'b1, 1'b1, 1);
        chk_state("empty_simul");
        chk("empty_simul_no_pulse", n_vld_a, vld_before);
        op(1'b0, 1'b1, 1);
        chk_state("final");

        chk("pulse_count_a", n_vld_a, n_pop_exp);
        chk("pulse_count_b", n_vld_b, n_pop_exp);
        chk("sb_empty_a", qa.size(), 0);
        chk("sb_empty_b", qb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
